// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
// Module   : display_pkg
// Purpose  : State codes shared by display_sequencer and the top-level controller.
// Revision : 1.0  initial release
// ============================================================================
package display_pkg;

    localparam logic [2:0] S_PE_IDLE      = 3'd0;
    localparam logic [2:0] S_PE_DISPLAY   = 3'd1;
    localparam logic [2:0] S_3X3_DISPLAY  = 3'd2;
    localparam logic [2:0] S_2X2_DISPLAY  = 3'd3;
    localparam logic [2:0] S_DONE_DISPLAY = 3'd4;

    typedef enum logic [2:0] {
        ST_PE_IDLE      = S_PE_IDLE,
        ST_PE_DISPLAY   = S_PE_DISPLAY,
        ST_3X3_DISPLAY  = S_3X3_DISPLAY,
        ST_2X2_DISPLAY  = S_2X2_DISPLAY,
        ST_DONE_DISPLAY = S_DONE_DISPLAY
    } state_t;

    function automatic logic is_showing(input logic [2:0] code);
        return (code >= S_PE_DISPLAY) && (code <= S_2X2_DISPLAY);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dwell_timer.sv
`default_nettype none
// ============================================================================
// Module   : dwell_timer
// Purpose  : Counts while run is high; pulses expire on the last dwell cycle.
// Revision : 1.0  initial release
// ============================================================================
module dwell_timer #(
    parameter int DWELL_CYCLES = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic clear,
    output logic expire
);

    localparam int CNT_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL_CYCLES - 1);

    logic [CNT_W-1:0] count;

    assign expire = run && (count == LAST);

    // Counter sits at zero whenever the sequencer is not actively showing a result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear || !run || expire) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/display_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : display_sequencer
// Purpose  : Snapshots PE/3x3/2x2 results and shows each for a dwell period.
//            Optional manual advance: define DISPLAY_MANUAL_ADVANCE_EN.
// Revision : 1.0  initial release
// ============================================================================
module display_sequencer
    import display_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int DWELL_CYCLES = 50_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              state_display,
    input  logic [DATA_W-1:0] pe_result,
    input  logic [DATA_W-1:0] sa3_result,
    input  logic [DATA_W-1:0] sa2_result,
    input  logic              next_btn,
    output logic [2:0]        current_display,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_valid
);

    state_t            state;
    logic [DATA_W-1:0] snap_pe;
    logic [DATA_W-1:0] snap_sa3;
    logic [DATA_W-1:0] snap_sa2;
    logic              showing;
    logic              expire;
    logic              btn_adv;
    logic              advance;

    assign showing = is_showing(state);

`ifdef DISPLAY_MANUAL_ADVANCE_EN
    logic [1:0] btn_sync;
    logic       btn_prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_sync <= 2'b00;
            btn_prev <= 1'b0;
        end else begin
            btn_sync <= {btn_sync[0], next_btn};
            btn_prev <= btn_sync[1];
        end
    end

    assign btn_adv = btn_sync[1] && !btn_prev && showing;
`else
    logic unused_next_btn;
    assign unused_next_btn = next_btn;
    assign btn_adv         = 1'b0;
`endif

    // A button edge and a timeout together still produce only one step.
    assign advance = expire || btn_adv;

    dwell_timer #(
        .DWELL_CYCLES (DWELL_CYCLES)
    ) u_dwell_timer (
        .clk    (clk),
        .reset  (reset),
        .run    (showing && state_display),
        .clear  (btn_adv),
        .expire (expire)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_PE_IDLE;
            snap_pe  <= '0;
            snap_sa3 <= '0;
            snap_sa2 <= '0;
        end else begin
            case (state)
                ST_PE_IDLE: begin
                    if (state_display) begin
                        state    <= ST_PE_DISPLAY;
                        snap_pe  <= pe_result;
                        snap_sa3 <= sa3_result;
                        snap_sa2 <= sa2_result;
                    end
                end
                ST_PE_DISPLAY: begin
                    if (!state_display) state <= ST_PE_IDLE;
                    else if (advance)   state <= ST_3X3_DISPLAY;
                end
                ST_3X3_DISPLAY: begin
                    if (!state_display) state <= ST_PE_IDLE;
                    else if (advance)   state <= ST_2X2_DISPLAY;
                end
                ST_2X2_DISPLAY: begin
                    if (!state_display) state <= ST_PE_IDLE;
                    else if (advance)   state <= ST_DONE_DISPLAY;
                end
                ST_DONE_DISPLAY: begin
                    if (!state_display) state <= ST_PE_IDLE;
                end
                default: state <= ST_PE_IDLE;
            endcase
        end
    end

    assign current_display = state;
    assign disp_valid      = showing;

    always_comb begin
        disp_data = '0;
        case (state)
            ST_PE_DISPLAY:  disp_data = snap_pe;
            ST_3X3_DISPLAY: disp_data = snap_sa3;
            ST_2X2_DISPLAY: disp_data = snap_sa2;
            default:        disp_data = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_display_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_display_sequencer
// Purpose  : Directed self-checking bench for display_sequencer (DWELL_CYCLES = 4).
// Revision : 1.0  initial release
// ============================================================================
module tb_display_sequencer;

    logic       clk;
    logic       reset;
    logic       state_display;
    logic [7:0] pe_result;
    logic [7:0] sa3_result;
    logic [7:0] sa2_result;
    logic       next_btn;
    logic [2:0] current_display;
    logic [7:0] disp_data;
    logic       disp_valid;

    int tests;
    int fails;

    display_sequencer #(
        .DATA_W       (8),
        .DWELL_CYCLES (4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .state_display   (state_display),
        .pe_result       (pe_result),
        .sa3_result      (sa3_result),
        .sa2_result      (sa2_result),
        .next_btn        (next_btn),
        .current_display (current_display),
        .disp_data       (disp_data),
        .disp_valid      (disp_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        state_display = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if (current_display !== 3'd0 || disp_valid !== 1'b0 || disp_data !== 8'h00) begin
                fails++;
                $display("FAIL reset_hold cyc%0d: got code=%0d valid=%0b data=%h, want 0/0/00",
                         i, current_display, disp_valid, disp_data);
            end
        end
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            tests++;
            if (current_display !== 3'd0 || disp_valid !== 1'b0 || disp_data !== 8'h00) begin
                fails++;
                $display("FAIL idle cyc%0d: got code=%0d valid=%0b data=%h, want 0/0/00",
                         i, current_display, disp_valid, disp_data);
            end
        end
    endtask

    task automatic test_full_sequence;
        logic [7:0] exp;
        pe_result = 8'h11; sa3_result = 8'h22; sa2_result = 8'h33;
        state_display = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            exp = (c == 1) ? 8'h11 : (c == 2) ? 8'h22 : 8'h33;
            for (int k = 0; k < 4; k++) begin
                tick();
                tests++;
                if (current_display !== 3'(c) || disp_valid !== 1'b1 || disp_data !== exp) begin
                    fails++;
                    $display("FAIL seq code%0d cyc%0d: got code=%0d valid=%0b data=%h, want %0d/1/%h",
                             c, k, current_display, disp_valid, disp_data, c, exp);
                end
                // Inputs change after entry; the snapshot must not follow them.
                if (c == 1 && k == 0) begin
                    pe_result = 8'hFF; sa3_result = 8'hEE; sa2_result = 8'hDD;
                end
            end
        end
        for (int k = 0; k < 2; k++) begin
            tick();
            tests++;
            if (current_display !== 3'd4 || disp_valid !== 1'b0 || disp_data !== 8'h00) begin
                fails++;
                $display("FAIL done cyc%0d: got code=%0d valid=%0b data=%h, want 4/0/00",
                         k, current_display, disp_valid, disp_data);
            end
        end
        state_display = 1'b0;
        tick();
        tests++;
        if (current_display !== 3'd0 || disp_valid !== 1'b0) begin
            fails++;
            $display("FAIL exit: got code=%0d valid=%0b, want 0/0", current_display, disp_valid);
        end
    endtask

    task automatic test_abort;
        pe_result = 8'h5A; sa3_result = 8'hA5; sa2_result = 8'h3C;
        state_display = 1'b1;
        for (int k = 0; k < 6; k++) tick();
        tests++;
        if (current_display !== 3'd2 || disp_data !== 8'hA5) begin
            fails++;
            $display("FAIL abort_pre: got code=%0d data=%h, want 2/a5", current_display, disp_data);
        end
        state_display = 1'b0;
        tick();
        tests++;
        if (current_display !== 3'd0 || disp_valid !== 1'b0 || disp_data !== 8'h00) begin
            fails++;
            $display("FAIL abort: got code=%0d valid=%0b data=%h, want 0/0/00",
                     current_display, disp_valid, disp_data);
        end
        tick();
        tests++;
        if (current_display !== 3'd0) begin
            fails++;
            $display("FAIL abort_hold: got code=%0d, want 0", current_display);
        end
    endtask

    task automatic test_async_reset;
        pe_result = 8'h44; sa3_result = 8'h55; sa2_result = 8'h66;
        state_display = 1'b1;
        for (int k = 0; k < 9; k++) tick();
        tests++;
        if (current_display !== 3'd3 || disp_data !== 8'h66) begin
            fails++;
            $display("FAIL areset_pre: got code=%0d data=%h, want 3/66", current_display, disp_data);
        end
        #2;
        reset = 1'b1;
        #1;
        tests++;
        if (current_display !== 3'd0 || disp_valid !== 1'b0 || disp_data !== 8'h00) begin
            fails++;
            $display("FAIL areset_async: got code=%0d valid=%0b data=%h, want 0/0/00",
                     current_display, disp_valid, disp_data);
        end
        state_display = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        tick();
        tests++;
        if (current_display !== 3'd0) begin
            fails++;
            $display("FAIL areset_noresume: got code=%0d, want 0", current_display);
        end
        pe_result = 8'h77;
        state_display = 1'b1;
        tick();
        tests++;
        if (current_display !== 3'd1 || disp_data !== 8'h77) begin
            fails++;
            $display("FAIL areset_restart: got code=%0d data=%h, want 1/77", current_display, disp_data);
        end
        state_display = 1'b0;
        tick();
    endtask

`ifdef DISPLAY_MANUAL_ADVANCE_EN
    task automatic test_manual_advance;
        int n;
        pe_result = 8'h11; sa3_result = 8'h22; sa2_result = 8'h33;
        state_display = 1'b1;
        tick();
        next_btn = 1'b1;
        tick();
        next_btn = 1'b0;
        n = 1;
        while (current_display !== 3'd2 && n < 4) begin
            tick();
            n++;
        end
        tests++;
        if (current_display !== 3'd2) begin
            fails++;
            $display("FAIL btn_latency: got code=%0d after %0d edges, want 2", current_display, n);
        end
        for (int k = 1; k < 4; k++) begin
            tick();
            tests++;
            if (current_display !== 3'd2 || disp_data !== 8'h22) begin
                fails++;
                $display("FAIL btn_dwell cyc%0d: got code=%0d data=%h, want 2/22",
                         k, current_display, disp_data);
            end
        end
        tick();
        tests++;
        if (current_display !== 3'd3) begin
            fails++;
            $display("FAIL btn_next: got code=%0d, want 3", current_display);
        end
        state_display = 1'b0;
        tick();
    endtask

    task automatic test_coincident;
        pe_result = 8'h11; sa3_result = 8'h22; sa2_result = 8'h33;
        state_display = 1'b1;
        for (int k = 0; k < 6; k++) tick();
        next_btn = 1'b1;
        tick();
        next_btn = 1'b0;
        tick();
        tests++;
        if (current_display !== 3'd2) begin
            fails++;
            $display("FAIL coinc_pre: got code=%0d, want 2", current_display);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            tests++;
            if (current_display !== 3'd3 || disp_data !== 8'h33) begin
                fails++;
                $display("FAIL coinc cyc%0d: got code=%0d data=%h, want 3/33",
                         k, current_display, disp_data);
            end
        end
        tick();
        tests++;
        if (current_display !== 3'd4) begin
            fails++;
            $display("FAIL coinc_done: got code=%0d, want 4", current_display);
        end
        state_display = 1'b0;
        tick();
    endtask
`endif

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        state_display = 1'b0;
        pe_result = 8'h00;
        sa3_result = 8'h00;
        sa2_result = 8'h00;
        next_btn = 1'b0;
        test_reset();
        test_full_sequence();
        test_abort();
        test_async_reset();
`ifdef DISPLAY_MANUAL_ADVANCE_EN
        test_manual_advance();
        test_coincident();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/display_sequencer.md
# display_sequencer

Drives the result-display phase of the capture → PE → systolic-array pipeline. The block sits directly downstream of the top-level controller: it is enabled by the controller's `state_display`, snapshots the PE, 3x3 and 2x2 results, and presents each in turn for a fixed dwell time. It reports its progress on `current_display`, and the controller uses that value to return to idle.

## Interface
- `DATA_W`, default 8: width of each result word and of `disp_data`.
- `DWELL_CYCLES`, default 50_000_000: cycles each result is shown (1 s at 50 MHz). Legal range is ≥ 2.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `state_display`  in  1  enable from the controller; high while the controller is in its display state.
- `pe_result`  in  DATA_W  PE-stage result.
- `sa3_result`  in  DATA_W  3x3 systolic-array result.
- `sa2_result`  in  DATA_W  2x2 systolic-array result.
- `next_btn`  in  1  asynchronous manual-advance button. It is used only when the macro in Configuration is defined.
- `current_display`  out  3  sequencer state code, fed back to the controller.
- `disp_data`  out  DATA_W  word to be shown.
- `disp_valid`  out  1  high while a result is being shown (codes 1–3).

## Operation
- State codes:
  - S_PE_IDLE = 0
  - S_PE_DISPLAY = 1
  - S_3x3_DISPLAY = 2
  - S_2x2_DISPLAY = 3
  - S_DONE_DISPLAY = 4
  - Codes 5–7 are illegal and go to S_PE_IDLE on the next edge.
- S_PE_IDLE, with `state_display` = 1: go to S_PE_DISPLAY. On the same edge, load all three results into snapshot registers and clear the dwell counter.
- S_PE_DISPLAY → S_3x3_DISPLAY → S_2x2_DISPLAY → S_DONE_DISPLAY. Each step happens on the edge where the dwell counter equals DWELL_CYCLES−1; that edge also clears the counter.
- S_DONE_DISPLAY:
  - Hold while `state_display` = 1.
  - Go to S_PE_IDLE on the first edge where `state_display` = 0.
- Abort: `state_display` = 0 in any of codes 1–3 sends the block to S_PE_IDLE on the next edge. Snapshots are retained but unused.
- `disp_data` mapping:
  - Code 1 shows the PE snapshot.
  - Code 2 shows the 3x3 snapshot.
  - Code 3 shows the 2x2 snapshot.
  - All other codes show 0.
- Snapshots are frozen for the whole sequence; input changes after entry are ignored.
- Dwell counter width is $clog2(DWELL_CYCLES). It counts only in codes 1–3 and holds 0 in all other states.

## Timing
- Reset values:
  - `current_display` = 0, `disp_data` = 0, `disp_valid` = 0.
  - Snapshots, dwell counter and button synchronizer all 0.
- All outputs are registered, or decoded only from registered state.
- Entry latency: one edge from the first sampled `state_display` = 1 to `current_display` = 1.
- Each of codes 1–3 lasts exactly DWELL_CYCLES cycles when no button press occurs.
- Closed-loop exit:
  - The controller sees code 4 and leaves its display state on edge E.
  - `state_display` is low after E.
  - The sequencer returns to 0 at E+1, so code 4 is visible for 2 cycles.
- Reset asserted mid-sequence clears everything immediately and asynchronously. The sequence does not resume.

## Configuration
- `DISPLAY_MANUAL_ADVANCE_EN` defined:
  - `next_btn` passes through a 2-flop synchronizer and a rising-edge detector.
  - A detected edge in codes 1–3 advances to the next code on the following edge and clears the dwell counter.
  - A button edge and a dwell timeout on the same cycle advance exactly one step.
  - Button edges in codes 0 and 4 are ignored.
- Macro undefined: `next_btn` is ignored, no synchronizer flops are built, and advance is by timeout only.

## Structure
- Shared package `display_pkg`: the five state-code localparams. The controller compares against the same S_DONE_DISPLAY = 4.
- One sub-module, `dwell_timer`, parameterised by DWELL_CYCLES:
  - Inputs: `clk`, `reset`, `run`, `clear`.
  - Output: `expire`, a single-cycle pulse at count DWELL_CYCLES−1.

## Test plan
Bench uses DWELL_CYCLES = 4 and DATA_W = 8.
- Reset then idle: hold `reset` 3 cycles with `state_display` = 0 → `current_display` = 0, `disp_valid` = 0, `disp_data` = 0 throughout.
- Full sequence: `pe_result` = 8'h11, `sa3_result` = 8'h22, `sa2_result` = 8'h33; raise `state_display` → codes 1, 2, 3 each for exactly 4 cycles with `disp_data` 11, 22, 33, then code 4. Drop `state_display` 1 cycle later → code 0 next edge.
- Snapshot freeze: change `pe_result` to 8'hFF during code 1 → `disp_data` stays 8'h11.
- Abort: drop `state_display` in cycle 2 of code 2 → code 0 on the next edge, `disp_valid` = 0.
- Async reset mid-code 3 → all outputs 0 without waiting for a clock edge; the sequence restarts at code 1 only on a new `state_display`.
- With `DISPLAY_MANUAL_ADVANCE_EN`:
  - A button pulse in cycle 1 of code 1 advances to code 2 after synchronizer latency (≤ 4 edges); code 2 then lasts a full 4 cycles.
  - A button edge coincident with timeout advances a single code.
